// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, read-only instruction cache sitting on the
// responder side of the fetch-stage instruction-memory port.
//  - A hit returns the instruction combinationally in the request cycle.
//  - A miss stalls fetch and refills one line from main memory, word by word.
// Optional feature: define ICACHE_STATS_EN to add saturating hit/miss
// counters (stat_hits_o / stat_misses_o). Without it those ports do not exist.
// Read/write encoding on imem_rd_wr_i: 0 = read, 1 = write (unsupported).
module icache_responder #(
    parameter int unsigned           INSTR_SIZE = 32,
    parameter int unsigned           NUM_LINES  = 16,
    parameter int unsigned           LINE_WORDS = 4,
    parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // fetch-stage port
    input  logic [INSTR_SIZE-1:0] imem_addr_i,
    input  logic                  imem_rd_wr_i,
    input  logic                  imem_op_en_i,
    output logic [INSTR_SIZE-1:0] imem_rd_instr_o,
    output logic                  imem_stall_o,
    // main-memory refill port
    output logic                  mem_req_o,
    output logic [INSTR_SIZE-1:0] mem_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [INSTR_SIZE-1:0] mem_rsp_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits_o,
    output logic [31:0]           stat_misses_o
`endif
);

    // ------------------------------------------------------------------
    // Address split: [1:0] byte | offset | index | tag
    // ------------------------------------------------------------------
    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(NUM_LINES);
    localparam int unsigned IDX_LSB = 2 + OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W   = INSTR_SIZE - TAG_LSB;
    localparam int unsigned LINE_W  = INSTR_SIZE - IDX_LSB;   // tag + index
    localparam int unsigned SLOTS   = NUM_LINES * LINE_WORDS;

    localparam logic             RD        = 1'b0;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE
    } state_e;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    state_e                  state_q;
    logic [LINE_W-1:0]       line_q;        // latched tag+index of the line being refilled
    logic [OFF_W-1:0]        cnt_q;         // refill beat counter
    logic [NUM_LINES-1:0]    valid_q;
    logic                    mem_req_q;
    logic [INSTR_SIZE-1:0]   mem_addr_q;
    logic [TAG_W-1:0]        tag_q  [NUM_LINES];
    logic [INSTR_SIZE-1:0]   data_q [SLOTS];

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]          addr_off;
    logic [IDX_W-1:0]          addr_idx;
    logic [TAG_W-1:0]          addr_tag;
    logic [IDX_W+OFF_W-1:0]    rd_slot;
    logic [IDX_W-1:0]          fill_idx;
    logic [TAG_W-1:0]          fill_tag;
    logic [IDX_W+OFF_W-1:0]    wr_slot;
    logic                      rd_req;
    logic                      hit;
    logic                      unused_byte_bits;

    assign addr_off = imem_addr_i[IDX_LSB-1:2];
    assign addr_idx = imem_addr_i[TAG_LSB-1:IDX_LSB];
    assign addr_tag = imem_addr_i[INSTR_SIZE-1:TAG_LSB];
    assign rd_slot  = {addr_idx, addr_off};

    assign fill_idx = line_q[IDX_W-1:0];
    assign fill_tag = line_q[LINE_W-1:IDX_W];
    assign wr_slot  = {fill_idx, cnt_q};

    // Byte-select bits play no part in an instruction-word cache.
    assign unused_byte_bits = ^imem_addr_i[1:0];

    assign rd_req = imem_op_en_i & (imem_rd_wr_i == RD);
    assign hit    = rd_req & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag)
                  & (state_q == S_IDLE);

    // Fetch-side outputs: same-cycle instruction on hit, otherwise NOP + stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        imem_rd_instr_o = NOP_INSTR;
        imem_stall_o    = (state_q != S_IDLE);
        if (hit) begin
            imem_rd_instr_o = data_q[rd_slot];
        end
        if (rd_req && !hit) begin
            imem_stall_o = 1'b1;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    // ------------------------------------------------------------------
    // Refill FSM: IDLE -> REQ -> FILL -> DONE -> IDLE, registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q    <= S_IDLE;
            line_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_req && !hit) begin
                        line_q     <= imem_addr_i[INSTR_SIZE-1:IDX_LSB];
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {imem_addr_i[INSTR_SIZE-1:IDX_LSB], {IDX_LSB{1'b0}}};
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // The request pulse lasts exactly this one cycle; the old
                    // contents of the victim line become invalid now.
                    mem_req_q         <= 1'b0;
                    valid_q[fill_idx] <= 1'b0;
                    cnt_q             <= '0;
                    state_q           <= S_FILL;
                end
                S_FILL: begin
                    if (mem_rsp_valid_i) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            valid_q[fill_idx] <= 1'b1;
                            state_q           <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // One bubble so the re-presented fetch sees a settled line.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line data and tag capture during FILL.
    always_ff @(posedge clk) begin
        // NOTE: the data and tag arrays carry no reset; valid_q alone decides whether their contents are used.
        if (state_q == S_FILL && mem_rsp_valid_i) begin
            data_q[wr_slot] <= mem_rsp_data_i;
            if (cnt_q == LAST_BEAT) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating lookup statistics, one count per IDLE-cycle read lookup.
    // ------------------------------------------------------------------
    logic [31:0] hits_q;
    logic [31:0] misses_q;
    logic        lookup;

    assign lookup = rd_req & (state_q == S_IDLE);

    // Count hits and misses, holding at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (lookup) begin
            if (hit) begin
                if (hits_q != '1) begin
                    hits_q <= hits_q + 32'd1;
                end
            end else begin
                if (misses_q != '1) begin
                    misses_q <= misses_q + 32'd1;
                end
            end
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: self-checking bench for icache_responder.
// Main memory is a fixed function of the word address; the reference model
// only tracks which line base is resident at each index. Optional
// ICACHE_STATS_EN checks are compiled in when the macro is defined.
module tb_icache_responder;

    localparam int          LW  = 4;
    localparam int          NL  = 16;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic        RD  = 1'b0;
    localparam logic        WR  = 1'b1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_addr_i;
    logic        imem_rd_wr_i;
    logic        imem_op_en_i;
    logic [31:0] imem_rd_instr_o;
    logic        imem_stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits_o;
    logic [31:0] stat_misses_o;
`endif

    always #5 clk = ~clk;

    icache_responder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_addr_i     (imem_addr_i),
        .imem_rd_wr_i    (imem_rd_wr_i),
        .imem_op_en_i    (imem_op_en_i),
        .imem_rd_instr_o (imem_rd_instr_o),
        .imem_stall_o    (imem_stall_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits_o     (stat_hits_o),
        .stat_misses_o   (stat_misses_o)
`endif
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: which line base (if any) lives at each index.
    bit          ref_valid [NL];
    logic [31:0] ref_base  [NL];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'h00000AA0;
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a >> 4) & 32'hF);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~32'hF;
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[ref_idx(a)] && (ref_base[ref_idx(a)] == line_base(a));
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic op, input logic rw, input logic [31:0] a);
        imem_op_en_i = op;
        imem_rd_wr_i = rw;
        imem_addr_i  = a;
    endtask

    // Plays main memory for one refill, starting at the (already settled)
    // miss cycle, until the fetch side stops stalling. Reports what it saw.
    task automatic run_miss(input logic [31:0] addr, input int gap, input bit kill,
                            output int req_cnt, output logic [31:0] req_addr,
                            output bit addr_held, output int stall_cycles,
                            output bit timed_out);
        logic [31:0] base;
        int          beats;
        int          wait_cnt;
        bit          done;
        base = line_base(addr);
        beats = 0; wait_cnt = 0; done = 1'b0;
        req_cnt = 0; req_addr = '0; addr_held = 1'b1; stall_cycles = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (mem_req_o === 1'b1) begin
                req_cnt++;
                req_addr = mem_addr_o;
            end
            if (imem_stall_o === 1'b0) begin
                done = 1'b1;
            end else begin
                stall_cycles++;
                if (req_cnt > 0 && mem_addr_o !== base) addr_held = 1'b0;
                tick();
                mem_rsp_valid_i = 1'b0;
                if (req_cnt > 0 && beats < LW) begin
                    if (wait_cnt == 0) begin
                        mem_rsp_valid_i = 1'b1;
                        mem_rsp_data_i  = mem_word(base + 32'(4 * beats));
                        beats++;
                        wait_cnt = gap;
                    end else begin
                        wait_cnt--;
                    end
                end
                if (kill && beats == 2) begin
                    imem_op_en_i = 1'b0;
                    imem_addr_i  = $urandom;
                end
                settle();
            end
        end
        timed_out = !done;
        if (done) begin
            ref_valid[ref_idx(addr)] = 1'b1;
            ref_base[ref_idx(addr)]  = base;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        drive(1'b1, RD, 32'h0);
        ref_clear();
        #2;
        total_cnt++;
        if (imem_stall_o !== 1'b1) $display("FAIL reset_stall_rd: got %b want 1", imem_stall_o); else pass_cnt++;
        total_cnt++;
        if (imem_rd_instr_o !== NOP) $display("FAIL reset_instr: got %h want %h", imem_rd_instr_o, NOP); else pass_cnt++;
        total_cnt++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0)
            $display("FAIL reset_mem_port: got req=%b addr=%h want 0/0", mem_req_o, mem_addr_o); else pass_cnt++;
        drive(1'b0, RD, 32'h0);
        #1;
        total_cnt++;
        if (imem_stall_o !== 1'b0) $display("FAIL reset_stall_idle: got %b want 0", imem_stall_o); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total_cnt++;
        if (imem_stall_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL post_reset_idle: got stall=%b req=%b want 0/0", imem_stall_o, mem_req_o); else pass_cnt++;
    endtask

    task automatic test_cold_start();
        int req_cnt, stall_cycles;
        logic [31:0] req_addr;
        bit held, to;
        tick();
        drive(1'b1, RD, 32'h0);
        settle();
        total_cnt++;
        if (imem_stall_o !== 1'b1 || imem_rd_instr_o !== NOP)
            $display("FAIL cold_miss: got stall=%b instr=%h want 1/%h", imem_stall_o, imem_rd_instr_o, NOP); else pass_cnt++;
        run_miss(32'h0, 0, 1'b0, req_cnt, req_addr, held, stall_cycles, to);
        total_cnt++;
        if (to) $display("FAIL cold_timeout: refill did not finish within 100 cycles"); else pass_cnt++;
        total_cnt++;
        if (req_cnt !== 1 || req_addr !== 32'h0)
            $display("FAIL cold_req: got pulses=%0d addr=%h want 1/00000000", req_cnt, req_addr); else pass_cnt++;
        total_cnt++;
        if (!held) $display("FAIL cold_addr_held: got changing mem_addr_o want steady 00000000"); else pass_cnt++;
        total_cnt++;
        if (stall_cycles !== 3 + LW) $display("FAIL cold_penalty: got %0d want %0d", stall_cycles, 3 + LW); else pass_cnt++;
        total_cnt++;
        if (imem_rd_instr_o !== 32'h00000AA0 || imem_stall_o !== 1'b0)
            $display("FAIL cold_hit: got instr=%h stall=%b want 00000aa0/0", imem_rd_instr_o, imem_stall_o); else pass_cnt++;
    endtask

    task automatic test_same_line_hits();
        logic [31:0] addrs [3];
        addrs = '{32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b1, RD, addrs[i]);
            settle();
            total_cnt++;
            if (imem_stall_o !== 1'b0 || imem_rd_instr_o !== mem_word(addrs[i]) || mem_req_o !== 1'b0)
                $display("FAIL line_hit_%0d: got stall=%b instr=%h req=%b want 0/%h/0",
                         i, imem_stall_o, imem_rd_instr_o, mem_req_o, mem_word(addrs[i]));
            else pass_cnt++;
        end
        tick();
        drive(1'b0, RD, 32'h0);
        settle();
`ifdef ICACHE_STATS_EN
        total_cnt++;
        if (stat_misses_o !== 32'd1 || stat_hits_o !== 32'd4)
            $display("FAIL stats: got hits=%0d misses=%0d want 4/1", stat_hits_o, stat_misses_o); else pass_cnt++;
`endif
    endtask

    task automatic test_conflict_miss();
        int req_cnt, stall_cycles;
        logic [31:0] req_addr;
        bit held, to;
        tick();
        drive(1'b1, RD, 32'h100);
        settle();
        total_cnt++;
        if (imem_stall_o !== 1'b1) $display("FAIL conflict_miss: got stall=%b want 1", imem_stall_o); else pass_cnt++;
        run_miss(32'h100, 0, 1'b0, req_cnt, req_addr, held, stall_cycles, to);
        total_cnt++;
        if (to || req_cnt !== 1 || req_addr !== 32'h100 || imem_rd_instr_o !== mem_word(32'h100))
            $display("FAIL conflict_fill: got to=%b pulses=%0d addr=%h instr=%h want 0/1/00000100/%h",
                     to, req_cnt, req_addr, imem_rd_instr_o, mem_word(32'h100));
        else pass_cnt++;
        tick();
        drive(1'b1, RD, 32'h0);
        settle();
        total_cnt++;
        if (imem_stall_o !== 1'b1 || imem_rd_instr_o !== NOP)
            $display("FAIL evicted_miss: got stall=%b instr=%h want 1/%h", imem_stall_o, imem_rd_instr_o, NOP); else pass_cnt++;
        run_miss(32'h0, 0, 1'b0, req_cnt, req_addr, held, stall_cycles, to);
        total_cnt++;
        if (to || imem_rd_instr_o !== 32'h00000AA0)
            $display("FAIL evicted_refill: got to=%b instr=%h want 0/00000aa0", to, imem_rd_instr_o); else pass_cnt++;
    endtask

    task automatic test_gapped_kill();
        int req_cnt, stall_cycles;
        logic [31:0] req_addr;
        bit held, to;
        tick();
        drive(1'b1, RD, 32'h104);
        settle();
        run_miss(32'h104, 2, 1'b1, req_cnt, req_addr, held, stall_cycles, to);
        total_cnt++;
        if (to || req_cnt !== 1 || !held)
            $display("FAIL gap_req: got to=%b pulses=%0d held=%b want 0/1/1", to, req_cnt, held); else pass_cnt++;
        total_cnt++;
        if (stall_cycles !== 3 + LW + 3 * 2)
            $display("FAIL gap_penalty: got %0d want %0d", stall_cycles, 3 + LW + 6); else pass_cnt++;
        tick();
        drive(1'b0, RD, 32'h0);
        tick();
        drive(1'b1, RD, 32'h100);
        settle();
        total_cnt++;
        if (imem_stall_o !== 1'b0 || imem_rd_instr_o !== mem_word(32'h100))
            $display("FAIL kill_line_hit: got stall=%b instr=%h want 0/%h", imem_stall_o, imem_rd_instr_o, mem_word(32'h100));
        else pass_cnt++;
    endtask

    task automatic test_write_and_stray();
        tick();
        drive(1'b1, WR, 32'h100);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hDEADBEEF;
        settle();
        total_cnt++;
        if (imem_stall_o !== 1'b0 || imem_rd_instr_o !== NOP)
            $display("FAIL write_op: got stall=%b instr=%h want 0/%h", imem_stall_o, imem_rd_instr_o, NOP); else pass_cnt++;
        tick();
        mem_rsp_valid_i = 1'b0;
        drive(1'b1, RD, 32'h108);
        settle();
        total_cnt++;
        if (imem_stall_o !== 1'b0 || imem_rd_instr_o !== mem_word(32'h108) || mem_req_o !== 1'b0)
            $display("FAIL after_write_hit: got stall=%b instr=%h req=%b want 0/%h/0",
                     imem_stall_o, imem_rd_instr_o, mem_req_o, mem_word(32'h108));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill();
        int req_cnt, stall_cycles;
        logic [31:0] req_addr;
        bit held, to;
        tick();
        drive(1'b1, RD, 32'h200);
        settle();
        tick();
        settle();
        total_cnt++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200)
            $display("FAIL midfill_req: got req=%b addr=%h want 1/00000200", mem_req_o, mem_addr_o); else pass_cnt++;
        for (int b = 0; b < 2; b++) begin
            tick();
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(32'h200 + 32'(4 * b));
        end
        tick();
        mem_rsp_valid_i = 1'b0;
        settle();
        reset_n = 1'b0;
        #1;
        ref_clear();
        total_cnt++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || imem_stall_o !== 1'b1 || imem_rd_instr_o !== NOP)
            $display("FAIL midfill_reset: got req=%b addr=%h stall=%b instr=%h want 0/00000000/1/%h",
                     mem_req_o, mem_addr_o, imem_stall_o, imem_rd_instr_o, NOP);
        else pass_cnt++;
        drive(1'b0, RD, 32'h0);
        #1;
        total_cnt++;
        if (imem_stall_o !== 1'b0) $display("FAIL midfill_idle: got stall=%b want 0", imem_stall_o); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        drive(1'b1, RD, 32'h100);
        settle();
        total_cnt++;
        if (imem_stall_o !== 1'b1) $display("FAIL midfill_valid_cleared: got stall=%b want 1", imem_stall_o); else pass_cnt++;
        run_miss(32'h100, 0, 1'b0, req_cnt, req_addr, held, stall_cycles, to);
        total_cnt++;
        if (to || stall_cycles !== 3 + LW || imem_rd_instr_o !== mem_word(32'h100))
            $display("FAIL midfill_refill: got to=%b penalty=%0d instr=%h want 0/%0d/%h",
                     to, stall_cycles, imem_rd_instr_o, 3 + LW, mem_word(32'h100));
        else pass_cnt++;
    endtask

    task automatic test_random();
        int req_cnt, stall_cycles, gap;
        logic [31:0] req_addr, a;
        logic op, rw;
        bit held, to, kill;
        for (int n = 0; n < 250; n++) begin
            tick();
            a = ({24'($urandom_range(0, 3)) | (24'($urandom_range(0, 1)) << 23)} << 8)
              | (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
            op = ($urandom_range(0, 3) != 0);
            rw = ($urandom_range(0, 7) == 0) ? WR : RD;
            drive(op, rw, a);
            mem_rsp_valid_i = 1'($urandom_range(0, 1));
            mem_rsp_data_i  = $urandom;
            settle();
            if (op && rw == RD && ref_hit(a)) begin
                total_cnt++;
                if (imem_stall_o !== 1'b0 || imem_rd_instr_o !== mem_word(a))
                    $display("FAIL rand_hit[%0d] a=%h: got stall=%b instr=%h want 0/%h",
                             n, a, imem_stall_o, imem_rd_instr_o, mem_word(a));
                else pass_cnt++;
            end else if (op && rw == RD) begin
                total_cnt++;
                if (imem_stall_o !== 1'b1 || imem_rd_instr_o !== NOP)
                    $display("FAIL rand_miss[%0d] a=%h: got stall=%b instr=%h want 1/%h",
                             n, a, imem_stall_o, imem_rd_instr_o, NOP);
                else pass_cnt++;
                gap  = $urandom_range(0, 2);
                kill = ($urandom_range(0, 3) == 0);
                run_miss(a, gap, kill, req_cnt, req_addr, held, stall_cycles, to);
                total_cnt++;
                if (to || req_cnt !== 1 || req_addr !== line_base(a) || !held || stall_cycles !== 3 + LW + 3 * gap)
                    $display("FAIL rand_refill[%0d] a=%h: got to=%b pulses=%0d addr=%h held=%b penalty=%0d want 0/1/%h/1/%0d",
                             n, a, to, req_cnt, req_addr, held, stall_cycles, line_base(a), 3 + LW + 3 * gap);
                else pass_cnt++;
                if (!kill) begin
                    total_cnt++;
                    if (imem_rd_instr_o !== mem_word(a))
                        $display("FAIL rand_post_fill[%0d] a=%h: got %h want %h", n, a, imem_rd_instr_o, mem_word(a));
                    else pass_cnt++;
                end
            end else begin
                total_cnt++;
                if (imem_stall_o !== 1'b0 || imem_rd_instr_o !== NOP)
                    $display("FAIL rand_noread[%0d] op=%b rw=%b: got stall=%b instr=%h want 0/%h",
                             n, op, rw, imem_stall_o, imem_rd_instr_o, NOP);
                else pass_cnt++;
            end
        end
        tick();
        drive(1'b0, RD, 32'h0);
        mem_rsp_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_same_line_hits();
        test_conflict_miss();
        test_gapped_kill();
        test_write_and_stray();
        test_reset_mid_fill();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
